// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the MEM stage: memory op codes, FSM state codes, fault causes,
// plus small op-class helpers used by the stage.
package cpu_mem_pkg;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LHU  = 4'd3;
  localparam logic [3:0] OP_LB   = 4'd4;
  localparam logic [3:0] OP_LBU  = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SB   = 4'd8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RMW  = 1'b1;

  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_RANGE    = 2'b10;

  function automatic logic op_is_load(input logic [3:0] op);
    return (op >= OP_LW) && (op <= OP_LBU);
  endfunction

  function automatic logic op_is_sub_store(input logic [3:0] op);
    return (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the word-addressed dmem (slave).
// rdata is combinational from addr within the same cycle.
interface mem_access_stage_if;
  logic        CS;
  logic        DM_R;
  logic        DM_W;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output CS, output DM_R, output DM_W, output addr, output wdata, input rdata);
  modport slave  (input CS, input DM_R, input DM_W, input addr, input wdata, output rdata);
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts and extends sub-word load data, and merges
// sub-word store data into the word read back from dmem.
module mem_lane_align
  import cpu_mem_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{byte_off, 3'b000} +: 8];
    half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];

    load_data = rdata;
    case (op)
      OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_data = {16'h0000, half_sel};
      OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_data = {24'h000000, byte_sel};
      default: load_data = rdata;
    endcase

    merge_data = rdata;
    if (op == OP_SB) begin
      merge_data[{byte_off, 3'b000} +: 8] = wdata[7:0];
    end else if (op == OP_SH) begin
      if (byte_off[1]) merge_data[31:16] = wdata[15:0];
      else             merge_data[15:0]  = wdata[15:0];
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives dmem strobes for loads/stores, performs SB/SH as a stalled
// read-modify-write, checks alignment/range faults and registers the MEM/WB result.
module mem_access_stage
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  input  logic [3:0]                ex_op,
  input  logic [31:0]               ex_addr,
  input  logic [31:0]               ex_wdata,
  input  logic [4:0]                ex_rd,
  input  logic                      ex_regwrite,
  mem_access_stage_if.master        dmem,
  output logic                      stall,
  output logic                      wb_valid,
  output logic [4:0]                wb_rd,
  output logic                      wb_regwrite,
  output logic [31:0]               wb_data,
  output logic                      exc,
  output logic [1:0]                exc_cause
);

  logic [0:0]  state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic        wb_regwrite_q, wb_regwrite_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        exc_q, exc_d;
  logic [1:0]  exc_cause_q, exc_cause_d;

  logic        is_load, is_sw, is_sub, is_mem;
  logic        misalign, out_of_range, fault;
  logic [31:0] load_data, merge_data;
  logic        cs, dm_r, dm_w, stall_c;
  logic [31:0] wdata_c;

  mem_lane_align u_lane_align (
    .op         (ex_op),
    .byte_off   (ex_addr[1:0]),
    .rdata      (dmem.rdata),
    .wdata      (ex_wdata),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    is_load  = op_is_load(ex_op);
    is_sw    = (ex_op == OP_SW);
    is_sub   = op_is_sub_store(ex_op);
    is_mem   = is_load | is_sw | is_sub;
    misalign = (((ex_op == OP_LW) || is_sw) && (ex_addr[1:0] != 2'b00)) ||
               (((ex_op == OP_LH) || (ex_op == OP_LHU) || (ex_op == OP_SH)) && ex_addr[0]);
    out_of_range = ((ex_addr >> (ADDR_W + 2)) != 32'd0);
    fault    = ex_valid && is_mem && (misalign || out_of_range);
  end

  // Strobes are gated by reset so an in-flight RMW write is dropped immediately.
  always_comb begin
    cs      = 1'b0;
    dm_r    = 1'b0;
    dm_w    = 1'b0;
    stall_c = 1'b0;
    wdata_c = 32'h0;
    if (rst) begin
      if (state_q == ST_RMW) begin
        cs      = 1'b1;
        dm_w    = 1'b1;
        wdata_c = merge_q;
      end else if (ex_valid && !fault) begin
        if (is_load) begin
          cs   = 1'b1;
          dm_r = 1'b1;
        end else if (is_sw) begin
          cs      = 1'b1;
          dm_w    = 1'b1;
          wdata_c = ex_wdata;
        end else if (is_sub) begin
          cs      = 1'b1;
          dm_r    = 1'b1;
          stall_c = 1'b1;
        end
      end
    end
  end

  assign dmem.CS    = cs;
  assign dmem.DM_R  = dm_r;
  assign dmem.DM_W  = dm_w;
  assign dmem.addr  = {2'b00, ex_addr[31:2]};
  assign dmem.wdata = wdata_c;
  assign stall      = stall_c;

  always_comb begin
    state_d       = state_q;
    merge_d       = merge_q;
    wb_valid_d    = 1'b0;
    wb_rd_d       = wb_rd_q;
    wb_regwrite_d = wb_regwrite_q;
    wb_data_d     = wb_data_q;
    exc_d         = 1'b0;
    exc_cause_d   = exc_cause_q;
    case (state_q)
      ST_RMW: begin
        wb_valid_d    = 1'b1;
        wb_rd_d       = ex_rd;
        wb_regwrite_d = 1'b0;
        state_d       = ST_IDLE;
      end
      default: begin
        if (ex_valid) begin
          if (fault) begin
            wb_valid_d    = 1'b1;
            wb_rd_d       = ex_rd;
            wb_regwrite_d = 1'b0;
            wb_data_d     = ex_addr;
            exc_d         = 1'b1;
            exc_cause_d   = misalign ? EXC_MISALIGN : EXC_RANGE;
          end else if (is_sub) begin
            merge_d = merge_data;
            state_d = ST_RMW;
          end else begin
            wb_valid_d    = 1'b1;
            wb_rd_d       = ex_rd;
            wb_regwrite_d = is_sw ? 1'b0 : ex_regwrite;
            wb_data_d     = is_load ? load_data : ex_addr;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      merge_q       <= 32'h0;
      wb_valid_q    <= 1'b0;
      wb_rd_q       <= 5'd0;
      wb_regwrite_q <= 1'b0;
      wb_data_q     <= 32'h0;
      exc_q         <= 1'b0;
      exc_cause_q   <= 2'b00;
    end else begin
      state_q       <= state_d;
      merge_q       <= merge_d;
      wb_valid_q    <= wb_valid_d;
      wb_rd_q       <= wb_rd_d;
      wb_regwrite_q <= wb_regwrite_d;
      wb_data_q     <= wb_data_d;
      exc_q         <= exc_d;
      exc_cause_q   <= exc_cause_d;
    end
  end

  assign wb_valid    = wb_valid_q;
  assign wb_rd       = wb_rd_q;
  assign wb_regwrite = wb_regwrite_q;
  assign wb_data     = wb_data_q;
  assign exc         = exc_q;
  assign exc_cause   = exc_cause_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a driver issues directed ops and queues the
// expected MEM/WB results; a monitor pops and compares whenever wb_valid is seen.
module tb_mem_access_stage;
  import cpu_mem_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        chk_data;
    logic [4:0]  rd;
    logic        regwrite;
    logic        exc;
    logic [1:0]  cause;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        stall;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        wb_regwrite;
  logic [31:0] wb_data;
  logic        exc;
  logic [1:0]  exc_cause;

  int          errors = 0;
  int          checks = 0;
  exp_t        sb_q[$];
  logic [1:0]  last_cause = 2'b00;
  logic [31:0] mem [2048];

  mem_access_stage_if dmem ();

  mem_access_stage #(.ADDR_W(11)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_op       (ex_op),
    .ex_addr     (ex_addr),
    .ex_wdata    (ex_wdata),
    .ex_rd       (ex_rd),
    .ex_regwrite (ex_regwrite),
    .dmem        (dmem.master),
    .stall       (stall),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_regwrite (wb_regwrite),
    .wb_data     (wb_data),
    .exc         (exc),
    .exc_cause   (exc_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural dmem: combinational read, write on the rising edge.
  assign dmem.rdata = mem[dmem.addr[10:0]];
  always @(posedge clk) begin
    if (dmem.CS && dmem.DM_W) mem[dmem.addr[10:0]] <= dmem.wdata;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && wb_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_wb_valid", 64'(wb_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (e.chk_data) check("wb_data", 64'(wb_data), 64'(e.data));
        check("wb_rd", 64'(wb_rd), 64'(e.rd));
        check("wb_regwrite", 64'(wb_regwrite), 64'(e.regwrite));
        check("exc", 64'(exc), 64'(e.exc));
        check("exc_cause", 64'(exc_cause), 64'(e.cause));
      end
    end
  end

  // Issue one op; exp_strb is {CS,DM_R,DM_W,stall} in its first cycle. Sub-word stores
  // are held for the RMW cycle, where exp_wd is the merged word to be written.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd, input logic rw, input logic [3:0] exp_strb,
                       input logic [31:0] exp_wd, input logic [31:0] exp_data,
                       input logic chk_data, input logic exp_exc, input logic [1:0] cause);
    exp_t e;
    @(negedge clk);
    ex_valid = 1'b1; ex_op = op; ex_addr = a; ex_wdata = wd; ex_rd = rd; ex_regwrite = rw;
    if (exp_exc) last_cause = cause;
    e.data = exp_data; e.chk_data = chk_data; e.rd = rd;
    e.regwrite = (exp_exc || op == OP_SW || op == OP_SH || op == OP_SB) ? 1'b0 : rw;
    e.exc = exp_exc; e.cause = last_cause;
    sb_q.push_back(e);
    #1;
    check("strobes_stall", 64'({dmem.CS, dmem.DM_R, dmem.DM_W, stall}), 64'(exp_strb));
    check("wdata", 64'(dmem.wdata), 64'((op == OP_SW) ? exp_wd : 32'h0));
    if (dmem.CS) check("addr", 64'(dmem.addr), 64'({2'b00, a[31:2]}));
    @(posedge clk);
    if (exp_strb[0]) begin
      #1;
      check("rmw_strobes", 64'({dmem.CS, dmem.DM_R, dmem.DM_W, stall}), 64'(4'b1010));
      check("rmw_wdata", 64'(dmem.wdata), 64'(exp_wd));
      @(posedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    rst = 1'b0; ex_valid = 1'b1; ex_op = OP_LW; ex_addr = 32'h10; ex_wdata = 32'h0;
    ex_rd = 5'd1; ex_regwrite = 1'b1;
    #12;
    check("reset_strobes", 64'({dmem.CS, dmem.DM_R, dmem.DM_W, stall}), 64'd0);
    check("reset_wb", 64'({wb_valid, wb_rd, wb_regwrite, wb_data, exc, exc_cause}), 64'd0);
    @(negedge clk); ex_valid = 1'b0; rst = 1'b1;

    // Word store then load back
    issue(OP_SW, 32'h10, 32'hDEADBEEF, 5'd2, 1'b1, 4'b1010, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 2'b00);
    issue(OP_LW, 32'h10, 32'h0, 5'd3, 1'b1, 4'b1100, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 2'b00);
    // SB read-modify-write, then byte loads
    issue(OP_SW, 32'h10, 32'h11223344, 5'd0, 1'b0, 4'b1010, 32'h11223344, 32'h0, 1'b0, 1'b0, 2'b00);
    issue(OP_SB, 32'h13, 32'h123456AA, 5'd4, 1'b0, 4'b1101, 32'hAA223344, 32'h0, 1'b0, 1'b0, 2'b00);
    issue(OP_LB, 32'h13, 32'h0, 5'd5, 1'b1, 4'b1100, 32'h0, 32'hFFFFFFAA, 1'b1, 1'b0, 2'b00);
    issue(OP_LBU, 32'h13, 32'h0, 5'd6, 1'b1, 4'b1100, 32'h0, 32'h000000AA, 1'b1, 1'b0, 2'b00);
    // SH read-modify-write, then halfword loads
    issue(OP_SW, 32'h10, 32'h11223344, 5'd0, 1'b0, 4'b1010, 32'h11223344, 32'h0, 1'b0, 1'b0, 2'b00);
    issue(OP_SH, 32'h12, 32'h00008001, 5'd7, 1'b0, 4'b1101, 32'h80013344, 32'h0, 1'b0, 1'b0, 2'b00);
    issue(OP_LH, 32'h12, 32'h0, 5'd8, 1'b1, 4'b1100, 32'h0, 32'hFFFF8001, 1'b1, 1'b0, 2'b00);
    issue(OP_LHU, 32'h12, 32'h0, 5'd10, 1'b1, 4'b1100, 32'h0, 32'h00008001, 1'b1, 1'b0, 2'b00);
    // Faults: misaligned load, out-of-range store
    issue(OP_LW, 32'h06, 32'h0, 5'd11, 1'b1, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, EXC_MISALIGN);
    issue(OP_SW, 32'h2000, 32'h55555555, 5'd12, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, EXC_RANGE);
    // NONE passes the ALU result, then a back-to-back stream with the fault cause held
    issue(OP_NONE, 32'h12345678, 32'h0, 5'd9, 1'b1, 4'b0000, 32'h0, 32'h12345678, 1'b1, 1'b0, 2'b00);
    issue(OP_LW, 32'h10, 32'h0, 5'd13, 1'b1, 4'b1100, 32'h0, 32'h80013344, 1'b1, 1'b0, 2'b00);
    issue(OP_SW, 32'h14, 32'hCAFEF00D, 5'd0, 1'b0, 4'b1010, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 2'b00);
    issue(OP_LB, 32'h14, 32'h0, 5'd14, 1'b1, 4'b1100, 32'h0, 32'h0000000D, 1'b1, 1'b0, 2'b00);
    issue(OP_LW, 32'h2FFC, 32'h0, 5'd15, 1'b1, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, EXC_RANGE);
    issue(OP_SH, 32'h11, 32'h0, 5'd16, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, EXC_MISALIGN);
    @(negedge clk); ex_valid = 1'b0;

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    check("mem_word5", 64'(mem[5]), 64'hCAFEF00D);

    // Reset while the SB is in its RMW cycle: the write must be dropped
    @(negedge clk);
    ex_valid = 1'b1; ex_op = OP_SB; ex_addr = 32'h10; ex_wdata = 32'h000000EE;
    ex_rd = 5'd17; ex_regwrite = 1'b0;
    #1 check("abort_stall", 64'(stall), 64'd1);
    @(posedge clk);
    rst = 1'b0;
    #1 check("abort_strobes", 64'({dmem.CS, dmem.DM_R, dmem.DM_W, stall}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("abort_wb", 64'({wb_valid, wb_rd, wb_regwrite, wb_data, exc, exc_cause}), 64'd0);
    check("abort_mem_word4", 64'(mem[4]), 64'h80013344);
    ex_valid = 1'b0; rst = 1'b1; last_cause = 2'b00;

    issue(OP_LW, 32'h10, 32'h0, 5'd18, 1'b1, 4'b1100, 32'h0, 32'h80013344, 1'b1, 1'b0, 2'b00);
    @(negedge clk); ex_valid = 1'b0;
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    check("final_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
